// File: rtl/rv_fetch_aligner_if.sv
// Fetch-word input channel and instruction output channel of the fetch aligner.
// The slave side is the aligner; the master side is the fetch unit plus decoder.
interface rv_fetch_aligner_if #(
    parameter int W = 64
);
    logic         fetch_valid;
    logic         fetch_ready;
    logic [W-1:0] fetch_addr;
    logic [31:0]  fetch_data;
    logic         fetch_fault;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_inst;
    logic [W-1:0] out_pc;
    logic         out_fault;

    modport slave (
        input  fetch_valid, fetch_addr, fetch_data, fetch_fault, out_ready,
        output fetch_ready, out_valid, out_inst, out_pc, out_fault
    );

    modport master (
        output fetch_valid, fetch_addr, fetch_data, fetch_fault, out_ready,
        input  fetch_ready, out_valid, out_inst, out_pc, out_fault
    );
endinterface

// File: rtl/rv_fetch_aligner.sv
// Splits aligned 32-bit fetch words into 16-bit parcels and issues whole RVC/32-bit
// instructions with their PC; drops stale words after redirect, halts on fetch fault.
//   state | meaning
//   RUN   | accepting fetch words and issuing instructions
//   HALT  | a faulted instruction was issued; frozen until redirect
module rv_fetch_aligner #(
    parameter bit          rv64     = 1'b1,
    parameter logic [63:0] reset_pc = 64'h0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  redirect,
    input  logic [(rv64 ? 64 : 32)-1:0]           redirect_pc,
    rv_fetch_aligner_if.slave                     bus
);
    localparam int W = rv64 ? 64 : 32;
    localparam logic [W-1:0] RST_PC = reset_pc[W-1:0];

    typedef enum logic {RUN, HALT} mode_e;

    // Each entry: {fault, parcel[15:0]}
    logic [16:0]  p_q [0:2];
    logic [16:0]  p_d [0:2];
    logic [16:0]  shifted [0:2];
    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_pc_q, head_pc_d;
    logic [W-1:0] expect_q, expect_d;
    logic         skip_low_q, skip_low_d;
    mode_e        mode_q, mode_d;

    logic         is32, complete, valid_int, fault_int, ready_int, fire, take;
    logic [1:0]   pop, rem;
    logic [2:0]   sum;

    // A faulted low parcel issues alone regardless of its opcode bits.
    assign is32      = (p_q[0][1:0] == 2'b11) && !p_q[0][16];
    assign complete  = ((count_q != 2'd0) && !is32) || (count_q >= 2'd2);
    assign valid_int = !reset && complete && (mode_q == RUN);
    assign fault_int = !reset && (p_q[0][16] || (is32 && p_q[1][16]));
    assign fire      = valid_int && bus.out_ready;
    assign pop       = fire ? (is32 ? 2'd2 : 2'd1) : 2'd0;
    assign rem       = count_q - pop;
    assign ready_int = !reset && (mode_q == RUN) && !redirect && (rem <= 2'd1);
    assign take      = bus.fetch_valid && ready_int && (bus.fetch_addr == expect_q);
    assign sum       = {1'b0, rem} + (take ? (skip_low_q ? 3'd1 : 3'd2) : 3'd0);

    assign bus.out_valid   = valid_int;
    assign bus.out_fault   = fault_int;
    assign bus.fetch_ready = ready_int;
    assign bus.out_pc      = reset ? RST_PC : head_pc_q;
    assign bus.out_inst    = reset ? 32'h0
                           : (is32 ? {p_q[1][15:0], p_q[0][15:0]} : {16'h0, p_q[0][15:0]});

    always_comb begin
        shifted[0] = p_q[0];
        shifted[1] = p_q[1];
        shifted[2] = p_q[2];
        case (pop)
            2'd1: begin
                shifted[0] = p_q[1];
                shifted[1] = p_q[2];
                shifted[2] = '0;
            end
            2'd2: begin
                shifted[0] = p_q[2];
                shifted[1] = '0;
                shifted[2] = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        p_d[0]     = shifted[0];
        p_d[1]     = shifted[1];
        p_d[2]     = shifted[2];
        count_d    = count_q;
        head_pc_d  = head_pc_q;
        expect_d   = expect_q;
        skip_low_d = skip_low_q;
        mode_d     = mode_q;

        if (redirect) begin
            count_d    = 2'd0;
            mode_d     = RUN;
            head_pc_d  = redirect_pc & ~W'(1);
            expect_d   = redirect_pc & ~W'(3);
            skip_low_d = redirect_pc[1];
        end else begin
            if (fire) begin
                head_pc_d = head_pc_q + (is32 ? W'(4) : W'(2));
                if (fault_int) mode_d = HALT;
            end
            if (take) begin
                if (skip_low_q) begin
                    p_d[rem] = {bus.fetch_fault, bus.fetch_data[31:16]};
                end else begin
                    p_d[rem]         = {bus.fetch_fault, bus.fetch_data[15:0]};
                    p_d[rem + 2'd1]  = {bus.fetch_fault, bus.fetch_data[31:16]};
                end
                skip_low_d = 1'b0;
                expect_d   = expect_q + W'(4);
            end
            count_d = sum[1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_q[0]     <= '0;
            p_q[1]     <= '0;
            p_q[2]     <= '0;
            count_q    <= 2'd0;
            mode_q     <= RUN;
            head_pc_q  <= RST_PC;
            expect_q   <= {RST_PC[W-1:2], 2'b00};
            skip_low_q <= RST_PC[1];
        end else begin
            p_q[0]     <= p_d[0];
            p_q[1]     <= p_d[1];
            p_q[2]     <= p_d[2];
            count_q    <= count_d;
            mode_q     <= mode_d;
            head_pc_q  <= head_pc_d;
            expect_q   <= expect_d;
            skip_low_q <= skip_low_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) assert (sum <= 3'd3);
    end
endmodule

// File: tb/tb_rv_fetch_aligner.sv
// Directed scenarios for rv_fetch_aligner (rv64, reset_pc=0) with hand-computed expectations.
module tb_rv_fetch_aligner;
    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    int          vectors = 0;
    int          miscompares = 0;

    rv_fetch_aligner_if #(.W(64)) bus ();

    rv_fetch_aligner #(.rv64(1'b1), .reset_pc(64'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        redirect        = 1'b0;
        redirect_pc     = 64'h0;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = 64'h0;
        bus.fetch_data  = 32'h0;
        bus.fetch_fault = 1'b0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic offer(input logic [63:0] addr, input logic [31:0] data, input logic flt);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = addr;
        bus.fetch_data  = data;
        bus.fetch_fault = flt;
    endtask

    task automatic check_out(input string name, input logic [31:0] inst,
                             input logic [63:0] pc, input logic flt);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_inst !== inst || bus.out_pc !== pc
            || bus.out_fault !== flt) begin
            miscompares++;
            $display("FAIL %s: got v=%b inst=%h pc=%h f=%b, expected v=1 inst=%h pc=%h f=%b",
                     name, bus.out_valid, bus.out_inst, bus.out_pc, bus.out_fault, inst, pc, flt);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        bus.fetch_valid = 1'b1;
        #1;
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_bit("reset_fetch_ready", bus.fetch_ready, 1'b0);
        check_bit("reset_out_fault", bus.out_fault, 1'b0);
        vectors++;
        if (bus.out_inst !== 32'h0 || bus.out_pc !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_inst_pc: got inst=%h pc=%h expected 0/0", bus.out_inst, bus.out_pc);
        end
        bus.fetch_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check_bit("post_reset_ready", bus.fetch_ready, 1'b1);
        check_bit("post_reset_valid", bus.out_valid, 1'b0);
    endtask

    task automatic test_single_32();
        do_reset();
        offer(64'h0, 32'h00A00513, 1'b0);
        #1;
        check_bit("single_ready", bus.fetch_ready, 1'b1);
        step();
        bus.fetch_valid = 1'b0;
        bus.out_ready   = 1'b1;
        #1;
        check_out("single_out", 32'h00A00513, 64'h0, 1'b0);
        check_bit("single_ready_on_fire", bus.fetch_ready, 1'b1);
        step();
        check_bit("single_drained", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_two_compressed();
        do_reset();
        offer(64'h0, 32'h45014505, 1'b0);
        step();
        offer(64'h4, 32'h00000001, 1'b0);
        #1;
        check_bit("two_c_full_ready", bus.fetch_ready, 1'b0);
        check_out("two_c_first_held", 32'h00004505, 64'h0, 1'b0);
        bus.fetch_valid = 1'b0;
        step();
        check_out("two_c_first_still", 32'h00004505, 64'h0, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        check_bit("two_c_ready_on_pop1", bus.fetch_ready, 1'b1);
        step();
        check_out("two_c_second", 32'h00004501, 64'h2, 1'b0);
        step();
        check_bit("two_c_drained", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_straddle();
        do_reset();
        offer(64'h0, 32'h05134501, 1'b0);
        step();
        bus.fetch_valid = 1'b0;
        bus.out_ready   = 1'b1;
        #1;
        check_out("straddle_c", 32'h00004501, 64'h0, 1'b0);
        step();
        check_bit("straddle_stall", bus.out_valid, 1'b0);
        step();
        check_bit("straddle_stall2", bus.out_valid, 1'b0);
        offer(64'h4, 32'h000000A0, 1'b0);
        #1;
        check_bit("straddle_ready", bus.fetch_ready, 1'b1);
        step();
        bus.fetch_valid = 1'b0;
        #1;
        check_out("straddle_32", 32'h00A00513, 64'h2, 1'b0);
        step();
        check_out("straddle_tail", 32'h00000000, 64'h6, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        offer(64'h0, 32'h45014505, 1'b0);
        step();
        redirect    = 1'b1;
        redirect_pc = 64'h102;
        offer(64'h100, 32'h45051234, 1'b0);
        #1;
        check_bit("redirect_blocks_fetch", bus.fetch_ready, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        check_bit("redirect_flushed", bus.out_valid, 1'b0);
        offer(64'h200, 32'hFFFFFFFF, 1'b0);
        #1;
        check_bit("redirect_ready", bus.fetch_ready, 1'b1);
        step();
        bus.fetch_valid = 1'b0;
        #1;
        check_bit("stale_dropped", bus.out_valid, 1'b0);
        offer(64'h100, 32'h45051234, 1'b0);
        step();
        bus.fetch_valid = 1'b0;
        #1;
        check_out("redirect_target", 32'h00004505, 64'h102, 1'b0);
        bus.out_ready = 1'b1;
        step();
        check_bit("redirect_drained", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fault_halt();
        do_reset();
        offer(64'h0, 32'h45010001, 1'b0);
        step();
        bus.out_ready = 1'b1;
        offer(64'h4, 32'h00000513, 1'b1);
        #1;
        check_out("fault_pre0", 32'h00000001, 64'h0, 1'b0);
        check_bit("fault_word_ready", bus.fetch_ready, 1'b1);
        step();
        bus.fetch_valid = 1'b0;
        bus.fetch_fault = 1'b0;
        #1;
        check_out("fault_pre2", 32'h00004501, 64'h2, 1'b0);
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_fault !== 1'b1 || bus.out_pc !== 64'h4) begin
            miscompares++;
            $display("FAIL fault_out: got v=%b f=%b pc=%h expected v=1 f=1 pc=4",
                     bus.out_valid, bus.out_fault, bus.out_pc);
        end
        step();
        offer(64'h8, 32'h00000001, 1'b0);
        #1;
        check_bit("halt_valid", bus.out_valid, 1'b0);
        check_bit("halt_ready", bus.fetch_ready, 1'b0);
        step();
        check_bit("halt_hold_valid", bus.out_valid, 1'b0);
        check_bit("halt_hold_ready", bus.fetch_ready, 1'b0);
        bus.fetch_valid = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        step();
        redirect = 1'b0;
        offer(64'h0, 32'h00A00513, 1'b0);
        #1;
        check_bit("halt_exit_ready", bus.fetch_ready, 1'b1);
        step();
        bus.fetch_valid = 1'b0;
        #1;
        check_out("halt_exit_out", 32'h00A00513, 64'h0, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        offer(64'h0, 32'h45014505, 1'b0);
        step();
        bus.out_ready = 1'b1;
        offer(64'h4, 32'h45024503, 1'b0);
        step();
        bus.fetch_valid = 1'b0;
        bus.out_ready   = 1'b0;
        #1;
        check_out("full_head", 32'h00004501, 64'h2, 1'b0);
        check_bit("full_not_ready", bus.fetch_ready, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_bit("midreset_valid", bus.out_valid, 1'b0);
        check_bit("midreset_ready", bus.fetch_ready, 1'b1);
        vectors++;
        if (bus.out_pc !== 64'h0) begin
            miscompares++;
            $display("FAIL midreset_pc: got %h expected 0", bus.out_pc);
        end
        offer(64'h0, 32'h00A00513, 1'b0);
        step();
        bus.fetch_valid = 1'b0;
        #1;
        check_out("midreset_fresh", 32'h00A00513, 64'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_32();
        test_two_compressed();
        test_straddle();
        test_redirect();
        test_fault_halt();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
